pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the five-stage MIPS pipeline.
- Drives hold/clear controls of PC, IF_ID, ID_EX and EX_MEM from three sources:
  - Tuse/Tnew data-hazard comparison against the E and M stages;
  - a multiply/divide busy sequencer;
  - exception/interrupt flush requests committed in M.
- Sits beside the pipeline registers. Its outputs gate their enable and clear inputs.

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu issues in E
- DIV_LAT, 10, busy cycles after a div/divu issues in E
- CNT_W, 4, busy counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  in  1  pipeline clock; rising edge active
- reset  in  1  one clock; reset is asynchronous and active-low (asserted at 0)
- rs_D  in  5  rs field of instruction in D
- rt_D  in  5  rt field of instruction in D
- Tuse_rs_D  in  2  cycles until rs is needed; 3 = not used
- Tuse_rt_D  in  2  cycles until rt is needed; 3 = not used
- RegWrite_E  in  1  E-stage instruction writes the GPR file
- Dst_E  in  5  E-stage destination register
- Tnew_E  in  2  cycles until E-stage result is available
- RegWrite_M  in  1  M-stage instruction writes the GPR file
- Dst_M  in  5  M-stage destination register
- Tnew_M  in  2  cycles until M-stage result is available
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- md_start_E  in  1  mult/div in E issues this cycle
- md_is_div_E  in  1  issuing op is div/divu
- exc_req_M  in  1  exception or interrupt taken at M
- stall  out  1  hold PC and IF_ID
- flush_E  out  1  clear ID_EX (insert bubble)
- flush_all  out  1  clear IF_ID, ID_EX, EX_MEM
- md_busy  out  1  MDU occupied
- busy_cnt  out  CNT_W  remaining busy cycles (debug/verification)

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE, busy_cnt=0.
  - Combinational outputs follow their equations: stall, flush_E, flush_all and md_busy are 0 when their inputs are 0.
- Data hazard, combinational:
  - hz_rs = rs_D!=0 && ((RegWrite_E && Dst_E==rs_D && Tuse_rs_D<Tnew_E) || (RegWrite_M && Dst_M==rs_D && Tuse_rs_D<Tnew_M)).
  - hz_rt is the same expression with rt_D and Tuse_rt_D.
  - A Tuse value of 3 never stalls, because Tnew is at most 2.
- MDU FSM states: IDLE, BUSY.
  - IDLE: on md_start_E && !exc_req_M, load busy_cnt = DIV_LAT if md_is_div_E else MULT_LAT, then go to BUSY.
  - BUSY: busy_cnt decrements each cycle. When busy_cnt==1, the next state is IDLE with busy_cnt=0.
  - md_start_E asserted while in BUSY is a protocol violation; it cannot occur because D is stalled. The block ignores it.
  - md_busy = (state==BUSY) || md_start_E. It covers the issue cycle itself.
  - exc_req_M does not abort a BUSY countdown: the issuing instruction is older and has already committed.
- md_stall = md_use_D && md_busy.
- stall = (hz_rs || hz_rt || md_stall) && !exc_req_M.
- flush_E = stall.
- flush_all = exc_req_M. It has priority over stall; stall and flush_E are forced to 0 that cycle.
- A simultaneous md_start_E and exc_req_M suppresses the load, because the E instruction is younger and is flushed.
- Latency:
  - Hazard, stall and flush outputs are same-cycle combinational.
  - The MDU result is consumable by an mfhi/mflo in D on the first cycle md_busy=0.
  - That is N+1 cycles after issue for latency N.
- Reset mid-BUSY returns to IDLE immediately; md_busy drops once md_start_E=0.

Decomposition:
- Shared package pipe_pkg holds:
  - TUSE_NONE=2'd3;
  - MULT_LAT and DIV_LAT defaults;
  - FSM state encoding IDLE=1'b0, BUSY=1'b1.
- One sub-module md_busy_seq: the FSM plus busy_cnt, with outputs md_busy and busy_cnt.
- Hazard comparison stays inline in the top level.

Test Plan:
- Load-use: rs_D=5, Tuse_rs_D=0, RegWrite_E=1, Dst_E=5, Tnew_E=2 -> stall=1 and flush_E=1. Next cycle, with Tnew_M=1 and Tuse_rs_D=0 -> stall=1. Then Tnew_M=0 -> stall=0.
- Register zero and unused operands:
  - rs_D=0 with Dst_E=0 and Tnew_E=2 -> stall=0.
  - Tuse_rt_D=3 with Dst_M=rt_D and Tnew_M=2 -> stall=0.
- mult issue:
  - md_start_E=1, md_is_div_E=0 -> busy_cnt=5 after the edge.
  - md_use_D=1 gives stall=1 for 6 consecutive cycles (the issue cycle plus 5).
  - busy_cnt counts 5,4,3,2,1,0; stall=0 on the cycle busy_cnt reaches 0.
- div issue -> busy_cnt=10, and md_busy stays high for 11 cycles including the issue cycle.
- Exception priority:
  - exc_req_M=1 together with hz_rs=1 -> flush_all=1, stall=0, flush_E=0.
  - exc_req_M=1 together with md_start_E=1 -> busy_cnt stays 0 and the state stays IDLE.
- Async reset: drive reset=0 mid-div while busy_cnt=6, between clock edges -> busy_cnt=0 and state=IDLE with no clock edge. Release reset, then a fresh mult -> busy_cnt=5.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
package pipe_pkg;

  localparam logic [1:0] TUSE_NONE    = 2'd3;
  localparam int         MULT_LAT_DEF = 5;
  localparam int         DIV_LAT_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 4
);
  import pipe_pkg::*;

  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic [1:0]       Tuse_rs_D;
  logic [1:0]       Tuse_rt_D;
  logic             RegWrite_E;
  logic [4:0]       Dst_E;
  logic [1:0]       Tnew_E;
  logic             RegWrite_M;
  logic [4:0]       Dst_M;
  logic [1:0]       Tnew_M;
  logic             md_use_D;
  logic             md_start_E;
  logic             md_is_div_E;
  logic             exc_req_M;
  logic             stall;
  logic             flush_E;
  logic             flush_all;
  logic             md_busy;
  logic [CNT_W-1:0] busy_cnt;
  md_state_e        md_state;

  // MDU contract: md_start_E may only be raised when md_busy was low the
  // cycle before (D is stalled otherwise); starts while busy are ignored.
  modport master (
    output rs_D, rt_D, Tuse_rs_D, Tuse_rt_D,
    output RegWrite_E, Dst_E, Tnew_E, RegWrite_M, Dst_M, Tnew_M,
    output md_use_D, md_start_E, md_is_div_E, exc_req_M,
    input  stall, flush_E, flush_all, md_busy, busy_cnt, md_state
  );

  modport slave (
    input  rs_D, rt_D, Tuse_rs_D, Tuse_rt_D,
    input  RegWrite_E, Dst_E, Tnew_E, RegWrite_M, Dst_M, Tnew_M,
    input  md_use_D, md_start_E, md_is_div_E, exc_req_M,
    output stall, flush_E, flush_all, md_busy, busy_cnt, md_state
  );

endinterface

// File: rtl/md_busy_seq.sv
// Multiply/divide occupancy sequencer: counts down the MDU latency after issue.
module md_busy_seq
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start_E,
  input  logic             md_is_div_E,
  input  logic             exc_req_M,
  output logic             md_busy,
  output logic [CNT_W-1:0] busy_cnt,
  output md_state_e        state
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A start alongside an exception belongs to a younger, flushed instruction.
        if (md_start_E && !exc_req_M) begin
          state_d = BUSY;
          cnt_d   = md_is_div_E ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy  = (state_q == BUSY) || md_start_E;
  assign busy_cnt = cnt_q;
  assign state    = state_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: data hazards, MDU busy, exceptions.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  logic hz_rs;
  logic hz_rt;
  logic md_stall;

  // Tuse of TUSE_NONE never stalls since Tnew tops out at 2.
  assign hz_rs = (bus.rs_D != 5'd0) &&
                 ((bus.RegWrite_E && (bus.Dst_E == bus.rs_D) && (bus.Tuse_rs_D < bus.Tnew_E)) ||
                  (bus.RegWrite_M && (bus.Dst_M == bus.rs_D) && (bus.Tuse_rs_D < bus.Tnew_M)));

  assign hz_rt = (bus.rt_D != 5'd0) &&
                 ((bus.RegWrite_E && (bus.Dst_E == bus.rt_D) && (bus.Tuse_rt_D < bus.Tnew_E)) ||
                  (bus.RegWrite_M && (bus.Dst_M == bus.rt_D) && (bus.Tuse_rt_D < bus.Tnew_M)));

  md_busy_seq #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_seq (
    .clk         (clk),
    .reset       (reset),
    .md_start_E  (bus.md_start_E),
    .md_is_div_E (bus.md_is_div_E),
    .exc_req_M   (bus.exc_req_M),
    .md_busy     (bus.md_busy),
    .busy_cnt    (bus.busy_cnt),
    .state       (bus.md_state)
  );

  assign md_stall      = bus.md_use_D && bus.md_busy;
  assign bus.stall     = (hz_rs || hz_rt || md_stall) && !bus.exc_req_M;
  assign bus.flush_E   = bus.stall;
  assign bus.flush_all = bus.exc_req_M;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, random hazard mix and MDU/reset sequences.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 4;
  localparam int W     = 4 + CNT_W;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic [1:0] trs, trt;
    logic       rwe;
    logic [4:0] dste;
    logic [1:0] tne;
    logic       rwm;
    logic [4:0] dstm;
    logic [1:0] tnm;
    logic       mduse, exc;
    logic [W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] exp_q[$];
  vec_t tbl[12];

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hif();

  pipe_hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=done");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string n, input logic [4:0] rs, rt, input logic [1:0] trs, trt,
                              input logic rwe, input logic [4:0] dste, input logic [1:0] tne,
                              input logic rwm, input logic [4:0] dstm, input logic [1:0] tnm,
                              input logic mduse, exc, input logic [W-1:0] e);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.trs = trs; v.trt = trt;
    v.rwe = rwe; v.dste = dste; v.tne = tne; v.rwm = rwm; v.dstm = dstm; v.tnm = tnm;
    v.mduse = mduse; v.exc = exc; v.exp = e;
    return v;
  endfunction

  task automatic drive_idle();
    hif.rs_D = '0; hif.rt_D = '0; hif.Tuse_rs_D = TUSE_NONE; hif.Tuse_rt_D = TUSE_NONE;
    hif.RegWrite_E = 1'b0; hif.Dst_E = '0; hif.Tnew_E = '0;
    hif.RegWrite_M = 1'b0; hif.Dst_M = '0; hif.Tnew_M = '0;
    hif.md_use_D = 1'b0; hif.md_start_E = 1'b0; hif.md_is_div_E = 1'b0; hif.exc_req_M = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    hif.rs_D = v.rs; hif.rt_D = v.rt; hif.Tuse_rs_D = v.trs; hif.Tuse_rt_D = v.trt;
    hif.RegWrite_E = v.rwe; hif.Dst_E = v.dste; hif.Tnew_E = v.tne;
    hif.RegWrite_M = v.rwm; hif.Dst_M = v.dstm; hif.Tnew_M = v.tnm;
    hif.md_use_D = v.mduse; hif.md_start_E = 1'b0; hif.md_is_div_E = 1'b0; hif.exc_req_M = v.exc;
  endtask

  // Pops the oldest expectation and compares it with the live outputs.
  task automatic compare(input string name);
    logic [W-1:0] e, a;
    a = {hif.stall, hif.flush_E, hif.flush_all, hif.md_busy, hif.busy_cnt};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: actual=%h required=<queued expectation>", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL %s: actual {stall,flush_E,flush_all,md_busy,cnt}=%b required=%b", name, a, e);
      end
    end
  endtask

  task automatic check_state(input string name, input md_state_e e);
    checks++;
    if (hif.md_state !== e) begin
      failures++;
      $display("FAIL %s: actual state=%0d required=%0d", name, hif.md_state, e);
    end
  endtask

  // Expectation pushed on drive; compared at the falling edge; returns just after the next rising edge.
  task automatic cycle(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    compare(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] e;
    logic hr, ht, st;
    int busy_cycles;

    tbl[0]  = mk("load_use_e",   5, 0, 0, 3, 1, 5, 2, 0, 0, 0, 0, 0, 8'hC0);
    tbl[1]  = mk("load_use_m1",  5, 0, 0, 3, 0, 0, 0, 1, 5, 1, 0, 0, 8'hC0);
    tbl[2]  = mk("load_use_m0",  5, 0, 0, 3, 0, 0, 0, 1, 5, 0, 0, 0, 8'h00);
    tbl[3]  = mk("rs_zero",      0, 0, 0, 3, 1, 0, 2, 0, 0, 0, 0, 0, 8'h00);
    tbl[4]  = mk("rt_unused",    0, 7, 3, 3, 0, 0, 0, 1, 7, 2, 0, 0, 8'h00);
    tbl[5]  = mk("rt_e_tuse1",   0, 7, 3, 1, 1, 7, 2, 0, 0, 0, 0, 0, 8'hC0);
    tbl[6]  = mk("rt_e_tuse_eq", 0, 7, 3, 2, 1, 7, 2, 0, 0, 0, 0, 0, 8'h00);
    tbl[7]  = mk("no_regwrite",  5, 0, 0, 3, 0, 5, 2, 0, 5, 2, 0, 0, 8'h00);
    tbl[8]  = mk("dst_differs",  5, 6, 0, 0, 1, 7, 2, 1, 8, 2, 0, 0, 8'h00);
    tbl[9]  = mk("exc_over_hz",  5, 0, 0, 3, 1, 5, 2, 0, 0, 0, 0, 1, 8'h20);
    tbl[10] = mk("md_use_idle",  0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    tbl[11] = mk("rt_m_only",    0, 9, 3, 0, 1, 9, 0, 1, 9, 1, 0, 0, 8'hC0);

    // Reset state, checked with no clock edge seen yet.
    reset = 1'b0;
    drive_idle();
    #3;
    exp_q.push_back(8'h00);
    compare("reset_outputs");
    check_state("reset_state", IDLE);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive_vec(tbl[i]);
      cycle(tbl[i].name, tbl[i].exp);
    end

    // Random hazard mix evaluated against the hazard equations; MDU stays idle.
    for (int k = 0; k < 40; k++) begin
      vec_t v;
      v = mk("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), '0);
      hr = (v.rs != 0) && ((v.rwe && v.dste == v.rs && v.trs < v.tne) ||
                           (v.rwm && v.dstm == v.rs && v.trs < v.tnm));
      ht = (v.rt != 0) && ((v.rwe && v.dste == v.rt && v.trt < v.tne) ||
                           (v.rwm && v.dstm == v.rt && v.trt < v.tnm));
      st = (hr || ht) && !v.exc;
      drive_vec(v);
      cycle("rand_hazard", {st, st, v.exc, 1'b0, 4'd0});
    end

    // Start with a simultaneous exception: load suppressed.
    drive_idle();
    hif.md_start_E = 1'b1; hif.md_is_div_E = 1'b1; hif.exc_req_M = 1'b1; hif.md_use_D = 1'b1;
    cycle("start_with_exc", 8'h30);
    drive_idle();
    exp_q.push_back(8'h00);
    @(negedge clk);
    compare("after_start_exc");
    check_state("after_start_exc_state", IDLE);
    @(posedge clk);
    #1;

    // mult with a dependent md_use in D; one exception mid-countdown must not abort it.
    drive_idle();
    hif.md_start_E = 1'b1; hif.md_use_D = 1'b1;
    cycle("mult_issue", 8'hD0);
    hif.md_start_E = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      hif.exc_req_M = (k == 3);
      e = (k == 3) ? (8'h30 | W'(k)) : (8'hD0 | W'(k));
      cycle("mult_count", e);
    end
    hif.exc_req_M = 1'b0;
    cycle("mult_done", 8'h00);

    // div: md_busy high for 11 cycles including issue.
    drive_idle();
    hif.md_start_E = 1'b1; hif.md_is_div_E = 1'b1;
    busy_cycles = 0;
    exp_q.push_back(8'h10);
    @(negedge clk);
    if (hif.md_busy) busy_cycles++;
    compare("div_issue");
    @(posedge clk);
    #1;
    drive_idle();
    for (int k = 10; k >= 1; k--) begin
      exp_q.push_back(8'h10 | W'(k));
      @(negedge clk);
      if (hif.md_busy) busy_cycles++;
      compare("div_count");
      @(posedge clk);
      #1;
    end
    cycle("div_done", 8'h00);
    checks++;
    if (busy_cycles != 11) begin
      failures++;
      $display("FAIL div_busy_cycles: actual=%0d required=11", busy_cycles);
    end

    // Async reset mid-div at busy_cnt=6, between edges.
    hif.md_start_E = 1'b1; hif.md_is_div_E = 1'b1;
    cycle("div2_issue", 8'h10);
    drive_idle();
    for (int k = 10; k >= 7; k--) cycle("div2_count", 8'h10 | W'(k));
    exp_q.push_back(8'h16);
    @(negedge clk);
    compare("div2_at6");
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(8'h00);
    compare("async_reset_outputs");
    check_state("async_reset_state", IDLE);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    hif.md_start_E = 1'b1;
    cycle("post_reset_mult_issue", 8'h10);
    drive_idle();
    exp_q.push_back(8'h15);
    @(negedge clk);
    compare("post_reset_mult_cnt");
    check_state("post_reset_busy_state", BUSY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
